mac_rx_len_filter: RTL
======================

// Module: mac_rx_len_filter
// PURPOSE
//  Stream stage directly downstream of the MAC group's rx output (out_data/out_ctrl/out_wr/out_rdy).
//  Inspects the IOQ module header of each received packet and forwards packets with legal byte length.
//  Drops runts, oversize frames and headerless fragments whole.
//  Output goes through a small FIFO toward the input arbiter.
// PARAMETERS
//  DATA_WIDTH      64    data bus width
//  CTRL_WIDTH      8     ctrl bus width (DATA_WIDTH/8)
//  MIN_BYTES       60    smallest legal byte length (inclusive)
//  MAX_BYTES       1518  largest legal byte length (inclusive)
//  FIFO_ADDR_BITS  2     output FIFO depth = 2**FIFO_ADDR_BITS words
// PORTS
//  clk          in   1           core clock
//  reset_n      in   1           async reset, active low
//  in_data      in   DATA_WIDTH  word from MAC rx queue
//  in_ctrl      in   CTRL_WIDTH  ctrl of in_data
//  in_wr        in   1           in_data/in_ctrl valid this cycle
//  in_rdy       out  1           stage can accept a word this cycle
//  out_data     out  DATA_WIDTH  word to input arbiter
//  out_ctrl     out  CTRL_WIDTH  ctrl of out_data
//  out_wr       out  1           out_data/out_ctrl valid, word consumed
//  out_rdy      in   1           downstream accepts a word this cycle
//  pkt_passed   out  1           1-cycle pulse: packet accepted
//  pkt_dropped  out  1           1-cycle pulse: packet rejected on length
//  sync_err     out  1           1-cycle pulse: non-header word discarded in SOP
// BEHAVIOUR
//  Reset: all outputs 0 except in_rdy (1 one cycle after release); FIFO empty; state SOP.
//  Reset mid-packet: flush FIFO, return to SOP. Remainder of the upstream packet is discarded through sync_err.
//  in_rdy = !fifo_full, combinational. in_wr while in_rdy=0 is illegal; the bench asserts on it.
//  out_wr = !fifo_empty & out_rdy; pop in the same cycle.
//  Min latency from in_wr to out_wr is 1 cycle. Simultaneous push and pop at full is not allowed (in_rdy=0).
//  Header word: ctrl==8'hFF; byte length = data[15:0]; len_ok = MIN_BYTES <= len <= MAX_BYTES.
//  FSM, advances only on in_wr:
//   SOP       : ctrl==FF & len_ok  -> push, pulse pkt_passed, go PASS_HDR
//               ctrl==FF & !len_ok -> no push, pulse pkt_dropped, go DROP_HDR
//               ctrl!=FF           -> no push, pulse sync_err, stay SOP
//   PASS_HDR  : push; ctrl==0 -> PASS_DATA; ctrl!=0 (further module headers) -> stay
//   PASS_DATA : push; ctrl!=0 (EOP) -> SOP
//   DROP_HDR  : no push; ctrl==0 -> DROP_DATA
//   DROP_DATA : no push; ctrl!=0 -> SOP
//  Dropped words never occupy the FIFO. in_rdy follows FIFO state during a drop as well.
//  Pulses are registered, asserted in the cycle after the header word, and mutually exclusive.
//  Pointers are FIFO_ADDR_BITS+1 bits and wrap naturally. Full/empty are derived from the MSB difference.
//  Words are forwarded unmodified; ordering is preserved.
// TESTING
//  1. len=64, 8 words, out_rdy=1 -> 8 out_wr beats identical to input, first one cycle after header; pkt_passed=1 once.
//  2. len=59 (runt), then len=1519 -> no out_wr; pkt_dropped pulses twice.
//     Following len=100 packet passes intact.
//  3. Boundaries len=60 and len=1518 -> both forwarded, pkt_passed x2.
//  4. out_rdy=0, stream 6-word packet -> in_rdy falls after 4 pushes.
//     out_rdy=1 -> all 6 words delivered in order, no loss, no duplicate.
//  5. First words ctrl=0 (headerless) x3, then valid header -> sync_err x3, then normal pass.
//  6. Assert reset_n=0 mid PASS_DATA with FIFO holding 3 words -> out_wr=0, FIFO empty.
//     Upstream tail triggers sync_err; next header packet passes.

Source files
------------

// File: rtl/mac_rx_len_filter.sv
// mac_rx_len_filter: forwards MAC rx packets whose IOQ header byte length is legal, drops the rest whole
// Ports:
//   clk, reset_n              core clock, async active-low reset
//   in_data/in_ctrl/in_wr     word from the MAC rx queue; in_rdy = stage can accept a word
//   out_data/out_ctrl/out_wr  word toward the input arbiter; out_rdy = downstream accepts a word
//   pkt_passed/pkt_dropped    1-cycle pulses after a header word that passed/failed the length check
//   sync_err                  1-cycle pulse after a non-header word discarded while waiting for a header
module mac_rx_len_filter #(
  parameter int DATA_WIDTH     = 64,
  parameter int CTRL_WIDTH     = 8,
  parameter int MIN_BYTES      = 60,
  parameter int MAX_BYTES      = 1518,
  parameter int FIFO_ADDR_BITS = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  output logic                  pkt_passed,
  output logic                  pkt_dropped,
  output logic                  sync_err
);
  localparam int DEPTH = 1 << FIFO_ADDR_BITS;
  localparam logic [15:0] MIN_L = 16'(MIN_BYTES);
  localparam logic [15:0] MAX_L = 16'(MAX_BYTES);
  typedef enum logic [2:0] {SOP, PASS_HDR, PASS_DATA, DROP_HDR, DROP_DATA} state_e;
  state_e state_q, state_d;
  logic [DATA_WIDTH+CTRL_WIDTH-1:0] mem_q [DEPTH];
  logic [FIFO_ADDR_BITS:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic rdy_q, passed_q, passed_d, dropped_q, dropped_d, sync_q, sync_d;
  logic full, empty, push, accept, is_hdr, len_ok, ctrl_zero;
  // Pointers carry one extra wrap bit: equal means empty, differing only in the MSB means full.
  assign empty     = wr_ptr_q == rd_ptr_q;
  assign full      = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {FIFO_ADDR_BITS{1'b0}}};
  // rdy_q holds in_rdy low until the first clock after reset release.
  assign in_rdy    = rdy_q & ~full;
  assign out_wr    = ~empty & out_rdy;
  assign {out_ctrl, out_data} = mem_q[rd_ptr_q[FIFO_ADDR_BITS-1:0]];
  assign accept    = in_wr & in_rdy;
  assign is_hdr    = in_ctrl == {CTRL_WIDTH{1'b1}};
  assign ctrl_zero = in_ctrl == '0;
  assign len_ok    = in_data[15:0] >= MIN_L && in_data[15:0] <= MAX_L;
  assign pkt_passed  = passed_q;
  assign pkt_dropped = dropped_q;
  assign sync_err    = sync_q;
  always_comb begin
    state_d   = state_q;
    push      = 1'b0;
    passed_d  = 1'b0;
    dropped_d = 1'b0;
    sync_d    = 1'b0;
    if (accept) begin
      case (state_q)
        SOP: begin
          push      = is_hdr & len_ok;
          passed_d  = is_hdr & len_ok;
          dropped_d = is_hdr & ~len_ok;
          sync_d    = ~is_hdr;
          state_d   = ~is_hdr ? SOP : len_ok ? PASS_HDR : DROP_HDR;
        end
        PASS_HDR: begin
          push    = 1'b1;
          state_d = ctrl_zero ? PASS_DATA : PASS_HDR;
        end
        PASS_DATA: begin
          push    = 1'b1;
          state_d = ctrl_zero ? PASS_DATA : SOP;
        end
        DROP_HDR:  state_d = ctrl_zero ? DROP_DATA : DROP_HDR;
        DROP_DATA: state_d = ctrl_zero ? DROP_DATA : SOP;
        default:   state_d = SOP;
      endcase
    end
  end
  assign wr_ptr_d = wr_ptr_q + {{FIFO_ADDR_BITS{1'b0}}, push};
  assign rd_ptr_d = rd_ptr_q + {{FIFO_ADDR_BITS{1'b0}}, out_wr};
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= SOP;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rdy_q     <= 1'b0;
      passed_q  <= 1'b0;
      dropped_q <= 1'b0;
      sync_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rdy_q     <= 1'b1;
      passed_q  <= passed_d;
      dropped_q <= dropped_d;
      sync_q    <= sync_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[FIFO_ADDR_BITS-1:0]] <= {in_ctrl, in_data};
  end
endmodule
